// File: rtl/seven_seg_arbiter.sv
// seven_seg_arbiter
//   Shares one four-digit seven-segment display among four 16-bit status
//   sources. Arbitration is round-robin. Each owner keeps the display for a
//   minimum dwell time so that the value on screen can be read. If an owner
//   drops its request, its last value stays frozen on the display.
//
// Parameters
//   DWELL      minimum number of cycles an owner keeps the display (1..65535)
//
// Ports
//   clk        system clock
//   rst_b      asynchronous reset, active low
//   req        level-sensitive request, one bit per source
//   values     source i value in values[16*i +: 16]
//   gnt        one-hot grant, registered; zero when idle
//   ss__owner  index of the current or most recent owner, registered
//   ss__value  value to display, registered; feeds seven_seg_control.ss__value
module seven_seg_arbiter #(
  parameter int unsigned DWELL = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [3:0]  req,
  input  logic [63:0] values,
  output logic [3:0]  gnt,
  output logic [1:0]  ss__owner,
  output logic [15:0] ss__value
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [15:0] LastCnt = 16'(DWELL - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  gnt_q;
  logic [1:0]  owner_q;
  logic [15:0] value_q;

  // Round-robin search, starting one past the current owner.
  logic        any_oth;   // some source other than the owner requests
  logic [1:0]  pick_oth;  // first such source in round-robin order
  logic        any_all;   // any source requests, owner included
  logic [1:0]  pick_all;  // first requester, owner considered last
  logic        owner_req;
  logic [15:0] owner_val;
  logic        expired;
  logic        take;      // load a new owner at this edge
  logic [1:0]  pick;
  logic [15:0] pick_val;

  always_comb begin
    any_oth  = 1'b0;
    pick_oth = owner_q;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = 3; k >= 1; k--) begin
      if (req[owner_q + 2'(k)]) begin
        any_oth  = 1'b1;
        pick_oth = owner_q + 2'(k);
      end
    end
    owner_req = req[owner_q];
    any_all   = any_oth | owner_req;
    pick_all  = any_oth ? pick_oth : owner_q;
    owner_val = values[{owner_q, 4'b0000} +: 16];
    expired   = (cnt_q == LastCnt);

    // In IDLE the previous owner is eligible; on preemption only the others.
    take = 1'b0;
    pick = pick_oth;
    unique case (state_q)
      StIdle: begin
        take = any_all;
        pick = pick_all;
      end
      StHold: begin
        take = expired & any_oth;
        pick = pick_oth;
      end
      default: begin
        take = 1'b0;
        pick = pick_oth;
      end
    endcase
    pick_val = values[{pick, 4'b0000} +: 16];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd3;      // makes source 0 the first pick
      value_q <= 16'h0000;
    end else if (take) begin
      state_q <= StHold;
      cnt_q   <= '0;
      gnt_q   <= 4'b0001 << pick;
      owner_q <= pick;
      value_q <= pick_val;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Nobody requests: everything holds, display is not blanked.
        end
        StHold: begin
          // Counter saturates at expiry; a re-raised request never restarts it.
          if (!expired) begin
            cnt_q <= cnt_q + 16'd1;
          end
          if (owner_req) begin
            value_q <= owner_val;
          end else if (expired) begin
            gnt_q   <= 4'b0000;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ss__owner = owner_q;
  assign ss__value = value_q;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Bench for seven_seg_arbiter. Three instances (DWELL = 4, 2, 1) share one
// stimulus stream; a cycle-level model tracks each and is compared on every
// falling edge, and directed literal checks pin the model at key points.
module tb_seven_seg_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [3:0]  req;
  logic [63:0] values;

  logic [3:0]  gnt_a [3];
  logic [1:0]  own_a [3];
  logic [15:0] val_a [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seven_seg_arbiter #(
      .DWELL(g == 0 ? 4 : (g == 1 ? 2 : 1))
    ) u_dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .req      (req),
      .values   (values),
      .gnt      (gnt_a[g]),
      .ss__owner(own_a[g]),
      .ss__value(val_a[g])
    );
  end

  function automatic int dwell_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  // First requesting index among owner+1 .. owner+span (mod 4), or -1.
  function automatic int first_req(logic [3:0] r, int own, int span);
    for (int k = 1; k <= span; k++) begin
      if (r[(own + k) % 4]) return (own + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age = number of clock edges since the current owner was granted.
  bit          m_busy  [3];
  int          m_owner [3];
  logic [15:0] m_val   [3];
  int          m_age   [3];

  always @(posedge clk or negedge rst_b) begin
    for (int i = 0; i < 3; i++) begin
      bit          busy;
      int          own;
      logic [15:0] v;
      int          age;
      int          cand;
      if (!rst_b) begin
        busy = 1'b0;
        own  = 3;
        v    = 16'h0;
        age  = 0;
      end else begin
        busy = m_busy[i];
        own  = m_owner[i];
        v    = m_val[i];
        age  = m_age[i];
        if (!busy) begin
          cand = first_req(req, own, 4);
          if (cand >= 0) begin
            busy = 1'b1;
            own  = cand;
            v    = values[cand*16 +: 16];
            age  = 0;
          end
        end else begin
          age  = age + 1;
          cand = (age >= dwell_of(i)) ? first_req(req, own, 3) : -1;
          if (cand >= 0) begin
            own = cand;
            v   = values[cand*16 +: 16];
            age = 0;
          end else if (req[own]) begin
            v = values[own*16 +: 16];
          end else if (age >= dwell_of(i)) begin
            busy = 1'b0;
          end
        end
      end
      m_busy[i]  <= busy;
      m_owner[i] <= own;
      m_val[i]   <= v;
      m_age[i]   <= age;
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("model_gnt", i, 32'(gnt_a[i]), m_busy[i] ? 32'(4'b0001 << m_owner[i]) : 32'h0);
      check("model_owner", i, 32'(own_a[i]), 32'(m_owner[i]));
      check("model_value", i, 32'(val_a[i]), 32'(m_val[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit(int i, logic [3:0] g, logic [1:0] o, logic [15:0] v);
    check("lit_gnt", i, 32'(gnt_a[i]), 32'(g));
    check("lit_owner", i, 32'(own_a[i]), 32'(o));
    check("lit_value", i, 32'(val_a[i]), 32'(v));
  endtask

  task automatic set_val(int i, logic [15:0] v);
    values[i*16 +: 16] = v;
  endtask

  initial begin
    rst_b  = 1'b0;
    req    = 4'hF;
    values = '0;

    // Reset held with every source requesting.
    repeat (3) begin
      tick(1);
      for (int i = 0; i < 3; i++) lit(i, 4'b0000, 2'd3, 16'h0000);
    end
    rst_b = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) lit(i, 4'b0001, 2'd0, 16'h0000);
    req = 4'b0000;
    tick(10);
    lit(0, 4'b0000, 2'd0, 16'h0000);

    // Single requester with live updates.
    set_val(2, 16'hBEEF);
    req = 4'b0100;
    tick(1);
    lit(0, 4'b0100, 2'd2, 16'hBEEF);
    set_val(2, 16'h1234);
    tick(1);
    lit(0, 4'b0100, 2'd2, 16'h1234);
    tick(5);
    lit(0, 4'b0100, 2'd2, 16'h1234);

    // Contention between sources 0 and 1 (owner 2 already expired).
    set_val(0, 16'h1111);
    set_val(1, 16'h2222);
    req = 4'b0011;
    tick(1);
    lit(0, 4'b0001, 2'd0, 16'h1111);
    tick(3);
    lit(0, 4'b0001, 2'd0, 16'h1111);
    tick(1);
    lit(0, 4'b0010, 2'd1, 16'h2222);
    tick(4);
    lit(0, 4'b0001, 2'd0, 16'h1111);

    // Early drop: owner 1 leaves its value frozen, then grant goes idle.
    set_val(1, 16'hCAFE);
    req = 4'b0010;
    tick(4);
    lit(0, 4'b0010, 2'd1, 16'hCAFE);
    tick(1);
    lit(0, 4'b0010, 2'd1, 16'hCAFE);
    req = 4'b0000;
    set_val(1, 16'h0BAD);
    tick(2);
    lit(0, 4'b0010, 2'd1, 16'hCAFE);
    tick(1);
    lit(0, 4'b0000, 2'd1, 16'hCAFE);
    tick(2);
    lit(0, 4'b0000, 2'd1, 16'hCAFE);

    // Wrap-around on the DWELL=2 instance: owner 3, then 0, 3, 0.
    tick(3);
    set_val(3, 16'h3333);
    req = 4'b1000;
    tick(1);
    lit(1, 4'b1000, 2'd3, 16'h3333);
    req = 4'b1001;
    tick(1);
    lit(1, 4'b1000, 2'd3, 16'h3333);
    tick(1);
    lit(1, 4'b0001, 2'd0, 16'h1111);
    tick(2);
    lit(1, 4'b1000, 2'd3, 16'h3333);
    tick(2);
    lit(1, 4'b0001, 2'd0, 16'h1111);

    // Reset asserted mid-hold takes effect without a clock edge.
    req = 4'b0000;
    tick(6);
    req = 4'b0010;
    tick(1);
    lit(0, 4'b0010, 2'd1, 16'h0BAD);
    tick(2);
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) lit(i, 4'b0000, 2'd3, 16'h0000);
    tick(2);
    lit(0, 4'b0000, 2'd3, 16'h0000);
    rst_b = 1'b1;
    tick(1);
    lit(0, 4'b0010, 2'd1, 16'h0BAD);
    req = 4'b0011;
    tick(3);
    lit(0, 4'b0010, 2'd1, 16'h0BAD);
    tick(1);
    lit(0, 4'b0001, 2'd0, 16'h1111);

    req = 4'b0000;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
